cdb_writeback_ctrl: RTL and testbench

- Sequences the single write port of the Tomasulo register file and arbitrates the common data bus (CDB) between functional units.
- Merges two write sources into one port:
  - issue-time dependency-tag writes;
  - completion-time result writes, with the matching tag cleared.
- Keeps a shadow copy of the per-register dependency tags, so it can map a completing tag back to its destination register.

---
 rtl/tomasulo_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/cdb_writeback_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_cdb_writeback_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: default widths, register-file geometry and
// the writeback state encoding.
package tomasulo_pkg;
  localparam int TAG_W     = 3;
  localparam int DATA_W    = 16;
  localparam int REG_IDX_W = 3;
  localparam int NUM_REGS  = 8;

  localparam logic [TAG_W-1:0] TAG_NONE = '0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WB   = 1'b1
  } wb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first requester at or after ptr_i (wrapping)
// wins. Outputs a one-hot grant plus the winner's index.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             vld_o
);
  logic [PTR_W-1:0] j;

  // Walk from the farthest candidate back to the pointer so the nearest hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j     = '0;
    for (int k = N-1; k >= 0; k--) begin
      j = PTR_W'((int'(ptr_i) + k) % N);
      if (req_i[j]) begin
        gnt_o    = '0;
        gnt_o[j] = 1'b1;
        idx_o    = j;
        vld_o    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cdb_writeback_ctrl.sv
// Register-file write sequencer and CDB arbiter for the Tomasulo core.
// Optional macro CDB_STALL_CNT_EN adds a saturating stall counter port.
module cdb_writeback_ctrl #(
  parameter int NUM_FU = 4,
  parameter int TAG_W  = tomasulo_pkg::TAG_W,
  parameter int DATA_W = tomasulo_pkg::DATA_W
) (
  input  logic                     CLK,
  input  logic                     CLR,
  input  logic [NUM_FU-1:0]        fu_req,
  input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU*DATA_W-1:0] fu_data,
  output logic [NUM_FU-1:0]        fu_gnt,
  input  logic                     iss_valid,
  input  logic [2:0]               iss_reg,
  input  logic [TAG_W-1:0]         iss_tag,
  output logic                     rf_wren,
  output logic [2:0]               rf_numW,
  output logic [TAG_W-1:0]         rf_depW,
  output logic [DATA_W-1:0]        rf_dataW,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_data
`ifdef CDB_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);
  import tomasulo_pkg::REG_IDX_W;
  import tomasulo_pkg::NUM_REGS;
  import tomasulo_pkg::TAG_NONE;
  import tomasulo_pkg::wb_state_e;
  import tomasulo_pkg::ST_IDLE;
  import tomasulo_pkg::ST_WB;

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  wb_state_e                            state_q, state_d;
  logic [PTR_W-1:0]                     ptr_q, ptr_d;
  logic [TAG_W-1:0]                     buf_tag_q, buf_tag_d;
  logic [DATA_W-1:0]                    buf_data_q, buf_data_d;
  logic [NUM_REGS-1:0][TAG_W-1:0]       dep_q, dep_d;
  logic                                 rf_wren_q, rf_wren_d;
  logic [REG_IDX_W-1:0]                 rf_num_q, rf_num_d;
  logic [TAG_W-1:0]                     rf_dep_q, rf_dep_d;
  logic [DATA_W-1:0]                    rf_data_q, rf_data_d;
  logic                                 cdb_vld_q, cdb_vld_d;
  logic [TAG_W-1:0]                     cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0]                    cdb_data_q, cdb_data_d;

  logic [NUM_FU-1:0][TAG_W-1:0]         tag_v;
  logic [NUM_FU-1:0][DATA_W-1:0]        data_v;
  logic                                 claim, complete, accept;
  logic [NUM_FU-1:0]                    arb_gnt;
  logic [PTR_W-1:0]                     arb_idx;
  logic                                 arb_vld;
  logic                                 hit;
  logic [REG_IDX_W-1:0]                 hit_idx;

  assign tag_v    = fu_tag;
  assign data_v   = fu_data;
  assign claim    = iss_valid && (iss_tag != TAG_W'(TAG_NONE));
  assign complete = (state_q == ST_WB) && !claim;
  assign accept   = (state_q == ST_IDLE) || complete;

  rr_arbiter #(.N(NUM_FU), .PTR_W(PTR_W)) u_arb (
    .req_i (fu_req & {NUM_FU{accept}}),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  assign fu_gnt = CLR ? '0 : arb_gnt;

  // Lowest register still waiting on the buffered tag; a superseded register misses.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int r = NUM_REGS-1; r >= 0; r--) begin
      if (dep_q[REG_IDX_W'(r)] == buf_tag_q) begin
        hit     = 1'b1;
        hit_idx = REG_IDX_W'(r);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    buf_tag_d  = buf_tag_q;
    buf_data_d = buf_data_q;
    dep_d      = dep_q;
    rf_wren_d  = 1'b0;
    rf_num_d   = rf_num_q;
    rf_dep_d   = rf_dep_q;
    rf_data_d  = rf_data_q;
    cdb_vld_d  = 1'b0;
    cdb_tag_d  = cdb_tag_q;
    cdb_data_d = cdb_data_q;

    if (claim) begin
      rf_wren_d      = 1'b1;
      rf_num_d       = iss_reg;
      rf_dep_d       = iss_tag;
      rf_data_d      = '0;
      dep_d[iss_reg] = iss_tag;
    end else if (complete) begin
      cdb_vld_d  = 1'b1;
      cdb_tag_d  = buf_tag_q;
      cdb_data_d = buf_data_q;
      state_d    = ST_IDLE;
      if (hit) begin
        rf_wren_d      = 1'b1;
        rf_num_d       = hit_idx;
        rf_dep_d       = '0;
        rf_data_d      = buf_data_q;
        dep_d[hit_idx] = '0;
      end
    end

    // A grant refills the buffer, overriding the IDLE return of a completion.
    if (arb_vld) begin
      buf_tag_d  = tag_v[arb_idx];
      buf_data_d = data_v[arb_idx];
      state_d    = ST_WB;
      ptr_d      = (arb_idx == PTR_W'(NUM_FU-1)) ? '0 : arb_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      buf_tag_q  <= '0;
      buf_data_q <= '0;
      dep_q      <= '0;
      rf_wren_q  <= 1'b0;
      rf_num_q   <= '0;
      rf_dep_q   <= '0;
      rf_data_q  <= '0;
      cdb_vld_q  <= 1'b0;
      cdb_tag_q  <= '0;
      cdb_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      buf_tag_q  <= buf_tag_d;
      buf_data_q <= buf_data_d;
      dep_q      <= dep_d;
      rf_wren_q  <= rf_wren_d;
      rf_num_q   <= rf_num_d;
      rf_dep_q   <= rf_dep_d;
      rf_data_q  <= rf_data_d;
      cdb_vld_q  <= cdb_vld_d;
      cdb_tag_q  <= cdb_tag_d;
      cdb_data_q <= cdb_data_d;
    end
  end

  assign rf_wren   = rf_wren_q;
  assign rf_numW   = rf_num_q;
  assign rf_depW   = rf_dep_q;
  assign rf_dataW  = rf_data_q;
  assign cdb_valid = cdb_vld_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;

`ifdef CDB_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      stall_cnt_q <= '0;
    end else if ((state_q == ST_WB) && claim && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_cdb_writeback_ctrl.sv
// Bench for cdb_writeback_ctrl: directed scenarios plus randomized traffic
// against a behavioural model of the writeback rules.
module tb_cdb_writeback_ctrl;
  localparam int N  = 4;
  localparam int TW = 3;
  localparam int DW = 16;

  logic            CLK = 1'b0;
  logic            CLR = 1'b0;
  logic [N-1:0]    fu_req;
  logic [N*TW-1:0] fu_tag;
  logic [N*DW-1:0] fu_data;
  logic [N-1:0]    fu_gnt;
  logic            iss_valid;
  logic [2:0]      iss_reg;
  logic [TW-1:0]   iss_tag;
  logic            rf_wren;
  logic [2:0]      rf_numW;
  logic [TW-1:0]   rf_depW;
  logic [DW-1:0]   rf_dataW;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
`ifdef CDB_STALL_CNT_EN
  logic [15:0]     stall_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  cdb_writeback_ctrl #(.NUM_FU(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .CLK(CLK), .CLR(CLR),
    .fu_req(fu_req), .fu_tag(fu_tag), .fu_data(fu_data), .fu_gnt(fu_gnt),
    .iss_valid(iss_valid), .iss_reg(iss_reg), .iss_tag(iss_tag),
    .rf_wren(rf_wren), .rf_numW(rf_numW), .rf_depW(rf_depW), .rf_dataW(rf_dataW),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
`ifdef CDB_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic idle_in();
    fu_req = '0; fu_tag = '0; fu_data = '0;
    iss_valid = 1'b0; iss_reg = '0; iss_tag = '0;
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    idle_in();
    CLR = 1'b1;
    step();
    CLR = 1'b0;
  endtask

  task automatic issue(input int r, input int t);
    iss_valid = 1'b1; iss_reg = 3'(r); iss_tag = TW'(t);
  endtask

  task automatic set_fu(input int i, input bit rq, input int t, input int d);
    fu_req[i] = rq;
    fu_tag[i*TW +: TW] = TW'(t);
    fu_data[i*DW +: DW] = DW'(d);
  endtask

  task automatic test_reset();
    idle_in();
    fu_req = '1;
    CLR = 1'b1;
    #2;
    n_chk++; if (fu_gnt !== 4'b0000) begin n_fail++; $display("FAIL rst_gnt: got %b want 0000", fu_gnt); end
    n_chk++;
    if ({rf_wren, rf_numW, rf_depW, rf_dataW, cdb_valid, cdb_tag, cdb_data} !== '0) begin
      n_fail++; $display("FAIL rst_outs: wren=%b num=%0d dep=%0d cv=%b ctag=%0d", rf_wren, rf_numW, rf_depW, cdb_valid, cdb_tag);
    end
    step();
    n_chk++; if (fu_gnt !== 4'b0000 || cdb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_hold: gnt=%b cv=%b want 0", fu_gnt, cdb_valid); end
`ifdef CDB_STALL_CNT_EN
    n_chk++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_stall: got %0d want 0", stall_cnt); end
`endif
    CLR = 1'b0;
    idle_in();
  endtask

  task automatic test_issue_complete();
    do_reset();
    issue(3, 2);
    step();
    n_chk++; if (rf_wren !== 1'b1 || rf_numW !== 3'd3 || rf_depW !== 3'd2 || rf_dataW !== 16'h0) begin
      n_fail++; $display("FAIL ic_issue: wren=%b num=%0d dep=%0d data=%h want 1/3/2/0", rf_wren, rf_numW, rf_depW, rf_dataW); end
    iss_valid = 1'b0;
    set_fu(0, 1, 2, 16'h00AA);
    #1;
    n_chk++; if (fu_gnt !== 4'b0001) begin n_fail++; $display("FAIL ic_gnt: got %b want 0001", fu_gnt); end
    step();
    n_chk++; if (rf_wren !== 1'b0 || cdb_valid !== 1'b0) begin n_fail++; $display("FAIL ic_quiet: wren=%b cv=%b want 0/0", rf_wren, cdb_valid); end
    set_fu(0, 0, 0, 0);
    step();
    n_chk++; if (cdb_valid !== 1'b1 || cdb_tag !== 3'd2 || cdb_data !== 16'h00AA) begin
      n_fail++; $display("FAIL ic_cdb: cv=%b tag=%0d data=%h want 1/2/00aa", cdb_valid, cdb_tag, cdb_data); end
    n_chk++; if (rf_wren !== 1'b1 || rf_numW !== 3'd3 || rf_depW !== 3'd0 || rf_dataW !== 16'h00AA) begin
      n_fail++; $display("FAIL ic_rf: wren=%b num=%0d dep=%0d data=%h want 1/3/0/00aa", rf_wren, rf_numW, rf_depW, rf_dataW); end
    step();
    n_chk++; if (cdb_valid !== 1'b0 || rf_wren !== 1'b0) begin n_fail++; $display("FAIL ic_pulse: cv=%b wren=%b want 0/0", cdb_valid, rf_wren); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) set_fu(i, 1, i + 1, 16'h0100 + i);
    for (int k = 0; k < 5; k++) begin
      logic [N-1:0] eg;
      eg = '0; eg[k % N] = 1'b1;
      #1;
      n_chk++; if (fu_gnt !== eg) begin n_fail++; $display("FAIL rr_gnt%0d: got %b want %b", k, fu_gnt, eg); end
      step();
      n_chk++;
      if (k == 0) begin
        if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL rr_cdb0: cv=%b want 0", cdb_valid); end
      end else if (cdb_valid !== 1'b1 || cdb_tag !== TW'(((k - 1) % N) + 1) || rf_wren !== 1'b0) begin
        n_fail++; $display("FAIL rr_cdb%0d: cv=%b tag=%0d wren=%b want 1/%0d/0", k, cdb_valid, cdb_tag, rf_wren, ((k - 1) % N) + 1);
      end
    end
    idle_in();
    step();
    n_chk++; if (cdb_valid !== 1'b1 || cdb_tag !== 3'd1 || cdb_data !== 16'h0100) begin
      n_fail++; $display("FAIL rr_last: cv=%b tag=%0d data=%h want 1/1/0100", cdb_valid, cdb_tag, cdb_data); end
  endtask

  task automatic test_stall();
    do_reset();
    issue(2, 5);
    step();
    iss_valid = 1'b0;
    set_fu(1, 1, 5, 16'h1234);
    #1;
    n_chk++; if (fu_gnt !== 4'b0010) begin n_fail++; $display("FAIL st_gnt: got %b want 0010", fu_gnt); end
    step();
    set_fu(1, 0, 0, 0);
    set_fu(0, 1, 3, 16'h0033);
    issue(6, 4);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++; if (fu_gnt !== 4'b0000) begin n_fail++; $display("FAIL st_nognt%0d: got %b want 0000", c, fu_gnt); end
      step();
      n_chk++; if (cdb_valid !== 1'b0 || rf_wren !== 1'b1 || rf_numW !== 3'd6 || rf_depW !== 3'd4) begin
        n_fail++; $display("FAIL st_hold%0d: cv=%b wren=%b num=%0d dep=%0d want 0/1/6/4", c, cdb_valid, rf_wren, rf_numW, rf_depW); end
    end
    iss_valid = 1'b0;
    #1;
    n_chk++; if (fu_gnt !== 4'b0001) begin n_fail++; $display("FAIL st_regnt: got %b want 0001", fu_gnt); end
    step();
    n_chk++; if (cdb_valid !== 1'b1 || cdb_tag !== 3'd5 || cdb_data !== 16'h1234) begin
      n_fail++; $display("FAIL st_cdb: cv=%b tag=%0d data=%h want 1/5/1234", cdb_valid, cdb_tag, cdb_data); end
    n_chk++; if (rf_wren !== 1'b1 || rf_numW !== 3'd2 || rf_depW !== 3'd0 || rf_dataW !== 16'h1234) begin
      n_fail++; $display("FAIL st_rf: wren=%b num=%0d dep=%0d data=%h want 1/2/0/1234", rf_wren, rf_numW, rf_depW, rf_dataW); end
`ifdef CDB_STALL_CNT_EN
    n_chk++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL st_cnt: got %0d want 3", stall_cnt); end
`endif
    set_fu(0, 0, 0, 0);
    step();
    n_chk++; if (cdb_valid !== 1'b1 || cdb_tag !== 3'd3 || rf_wren !== 1'b0) begin
      n_fail++; $display("FAIL st_nomatch: cv=%b tag=%0d wren=%b want 1/3/0", cdb_valid, cdb_tag, rf_wren); end
  endtask

  task automatic test_superseded();
    do_reset();
    issue(4, 6);
    step();
    issue(4, 7);
    step();
    iss_valid = 1'b0;
    set_fu(2, 1, 6, 16'h0BEE);
    #1;
    n_chk++; if (fu_gnt !== 4'b0100) begin n_fail++; $display("FAIL sup_gnt: got %b want 0100", fu_gnt); end
    step();
    set_fu(2, 0, 0, 0);
    set_fu(3, 1, 7, 16'h0C0D);
    #1;
    n_chk++; if (fu_gnt !== 4'b1000) begin n_fail++; $display("FAIL sup_gnt2: got %b want 1000", fu_gnt); end
    step();
    n_chk++; if (cdb_valid !== 1'b1 || cdb_tag !== 3'd6 || cdb_data !== 16'h0BEE || rf_wren !== 1'b0) begin
      n_fail++; $display("FAIL sup_bcast: cv=%b tag=%0d data=%h wren=%b want 1/6/0bee/0", cdb_valid, cdb_tag, cdb_data, rf_wren); end
    set_fu(3, 0, 0, 0);
    step();
    n_chk++; if (cdb_valid !== 1'b1 || cdb_tag !== 3'd7 || rf_wren !== 1'b1 || rf_numW !== 3'd4 || rf_dataW !== 16'h0C0D) begin
      n_fail++; $display("FAIL sup_dep7: cv=%b tag=%0d wren=%b num=%0d data=%h want 1/7/1/4/0c0d", cdb_valid, cdb_tag, rf_wren, rf_numW, rf_dataW); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_fu(0, 1, 1, 16'h0055);
    #1;
    n_chk++; if (fu_gnt !== 4'b0001) begin n_fail++; $display("FAIL rm_gnt: got %b want 0001", fu_gnt); end
    step();
    for (int i = 0; i < N; i++) set_fu(i, 1, i + 2, 16'h0060 + i);
    CLR = 1'b1;
    #1;
    n_chk++; if (fu_gnt !== 4'b0000) begin n_fail++; $display("FAIL rm_gntclr: got %b want 0000", fu_gnt); end
    step();
    n_chk++;
    if ({rf_wren, rf_numW, rf_depW, rf_dataW, cdb_valid, cdb_tag, cdb_data} !== '0) begin
      n_fail++; $display("FAIL rm_outs: wren=%b cv=%b ctag=%0d want all 0", rf_wren, cdb_valid, cdb_tag);
    end
    CLR = 1'b0;
    #1;
    n_chk++; if (fu_gnt !== 4'b0001) begin n_fail++; $display("FAIL rm_first: got %b want 0001", fu_gnt); end
    step();
    n_chk++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL rm_nocdb: cv=%b tag=%0d want 0", cdb_valid, cdb_tag); end
    idle_in();
    step();
    n_chk++; if (cdb_valid !== 1'b1 || cdb_tag !== 3'd2 || cdb_data !== 16'h0060) begin
      n_fail++; $display("FAIL rm_cdb: cv=%b tag=%0d data=%h want 1/2/0060", cdb_valid, cdb_tag, cdb_data); end
  endtask

  task automatic test_tag0_issue();
    do_reset();
    issue(1, 3);
    step();
    iss_valid = 1'b0;
    set_fu(0, 1, 3, 16'h0077);
    step();
    set_fu(0, 0, 0, 0);
    set_fu(1, 1, 5, 16'h0099);
    issue(5, 0);
    #1;
    n_chk++; if (fu_gnt !== 4'b0010) begin n_fail++; $display("FAIL t0_gnt: got %b want 0010", fu_gnt); end
    step();
    n_chk++; if (cdb_valid !== 1'b1 || cdb_tag !== 3'd3 || rf_wren !== 1'b1 || rf_numW !== 3'd1 || rf_depW !== 3'd0 || rf_dataW !== 16'h0077) begin
      n_fail++; $display("FAIL t0_wb: cv=%b tag=%0d wren=%b num=%0d dep=%0d data=%h want 1/3/1/1/0/0077", cdb_valid, cdb_tag, rf_wren, rf_numW, rf_depW, rf_dataW); end
    idle_in();
    step();
    n_chk++; if (cdb_valid !== 1'b1 || cdb_tag !== 3'd5 || rf_wren !== 1'b0) begin
      n_fail++; $display("FAIL t0_next: cv=%b tag=%0d wren=%b want 1/5/0", cdb_valid, cdb_tag, rf_wren); end
  endtask

  task automatic test_random();
    int  mdep[8];
    bit  mfull;
    int  mtag, mdata, mptr;
    int  e_num, e_dep, e_data, e_ctag, e_cdata, e_stall;
    bit  e_wren, e_cv;
    do_reset();
    foreach (mdep[r]) mdep[r] = 0;
    mfull = 0; mtag = 0; mdata = 0; mptr = 0;
    e_num = 0; e_dep = 0; e_data = 0; e_ctag = 0; e_cdata = 0; e_stall = 0;
    for (int c = 0; c < 400; c++) begin
      bit claim, comp, acc;
      int g, hit;
      logic [N-1:0] eg;
      iss_valid = ($urandom_range(0, 9) < 4);
      iss_reg   = 3'($urandom_range(0, 7));
      iss_tag   = TW'($urandom_range(0, 7));
      for (int i = 0; i < N; i++) set_fu(i, ($urandom_range(0, 2) != 0), $urandom_range(1, 7), $urandom);
      claim = iss_valid && (iss_tag != 0);
      comp  = mfull && !claim;
      acc   = !mfull || comp;
      g = -1;
      if (acc) for (int k = 0; k < N; k++) if (g < 0 && fu_req[(mptr + k) % N]) g = (mptr + k) % N;
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      #1;
      n_chk++; if (fu_gnt !== eg) begin n_fail++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, fu_gnt, eg); end
      e_wren = 0; e_cv = 0;
      if (claim) begin
        e_wren = 1; e_num = iss_reg; e_dep = iss_tag; e_data = 0;
        mdep[iss_reg] = iss_tag;
        if (mfull) e_stall++;
      end else if (comp) begin
        e_cv = 1; e_ctag = mtag; e_cdata = mdata;
        hit = -1;
        for (int r = 0; r < 8; r++) if (hit < 0 && mdep[r] == mtag) hit = r;
        if (hit >= 0) begin
          e_wren = 1; e_num = hit; e_dep = 0; e_data = mdata; mdep[hit] = 0;
        end
        mfull = 0;
      end
      if (g >= 0) begin
        mfull = 1;
        mtag  = fu_tag[g*TW +: TW];
        mdata = fu_data[g*DW +: DW];
        mptr  = (g + 1) % N;
      end
      step();
      n_chk++; if (rf_wren !== e_wren || {rf_numW, rf_depW, rf_dataW} !== {3'(e_num), TW'(e_dep), DW'(e_data)}) begin
        n_fail++; $display("FAIL rnd_rf c%0d: wren=%b num=%0d dep=%0d data=%h want %b/%0d/%0d/%h", c, rf_wren, rf_numW, rf_depW, rf_dataW, e_wren, e_num, e_dep, DW'(e_data)); end
      n_chk++; if (cdb_valid !== e_cv || {cdb_tag, cdb_data} !== {TW'(e_ctag), DW'(e_cdata)}) begin
        n_fail++; $display("FAIL rnd_cdb c%0d: cv=%b tag=%0d data=%h want %b/%0d/%h", c, cdb_valid, cdb_tag, cdb_data, e_cv, e_ctag, DW'(e_cdata)); end
    end
`ifdef CDB_STALL_CNT_EN
    n_chk++; if (stall_cnt !== 16'(e_stall)) begin n_fail++; $display("FAIL rnd_stall: got %0d want %0d", stall_cnt, e_stall); end
`endif
  endtask

  initial begin
    idle_in();
    #3;
    test_reset();
    test_issue_complete();
    test_round_robin();
    test_stall();
    test_superseded();
    test_reset_mid();
    test_tag0_issue();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
